phase_sequencer: RTL and testbench

Control-phase generator for the 16-bit pipelined-multiplier CPU, directly upstream of the instruction decoder. It produces the one-hot `fe`/`e1`/`e2` phase strobes and presents the current instruction word to the decoder, using a bypass in E1 and a held instruction register (IR) afterwards. It stretches two-cycle instructions, waits on the multiplier for `mlr`, and halts on `stp`. It also keeps a retired-instruction counter for debug.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/phase_sequencer.sv | 126 ++++++++++++
 tb/tb_phase_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined-multiplier CPU control path.
// The phase enum and opcode constants are meant to be reused by the instruction decoder.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC1 = 3'd1,
        EXEC2 = 3'd2,
        MWAIT = 3'd3,
        HALT  = 3'd4
    } phase_t;

    localparam logic [4:0] OP_STP = 5'b00000;
    localparam logic [4:0] OP_MLR = 5'b01001;

    localparam int WAIT_W = 4;

endpackage : cpu_pkg

// File: rtl/phase_sequencer.sv
// Control-phase generator: one-hot fe/e1/e2 strobes, instruction bypass/hold for the
// decoder, multiplier wait with timeout, halt/run handling and a retired-instruction count.
module phase_sequencer
    import cpu_pkg::*;
#(
    parameter int MUL_TIMEOUT = 15,
    parameter int RETIRE_W    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [15:0]         instr_q,
    input  logic                extra1,
    input  logic                mul_done,
    input  logic                run,
    output logic [15:0]         instr,
    output logic                fe,
    output logic                e1,
    output logic                e2,
    output logic                mul_start,
    output logic                halted,
    output logic                mul_err,
    output logic [RETIRE_W-1:0] retired
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MUL_TIMEOUT);

    phase_t              r_state;
    phase_t              w_next;
    logic [15:0]         r_ir;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_mul_err;
    logic [RETIRE_W-1:0] r_retired;

    logic [4:0]          w_opcode;
    logic                w_stp;
    logic                w_mlr;
    logic                w_wait_max;
    logic                w_timeout;
    logic                w_retire;

    // The decoder sees fresh memory data in E1 and the held copy for the rest of the instruction.
    assign instr    = (r_state == EXEC1) ? instr_q : r_ir;
    assign w_opcode = instr[15:11];
    assign w_stp    = (w_opcode == OP_STP);
    assign w_mlr    = (w_opcode == OP_MLR);

    assign w_wait_max = (r_wait == WAIT_MAX);
    assign w_timeout  = (r_state == MWAIT) && w_wait_max && !mul_done;
    assign w_retire   = (w_next == FETCH) && ((r_state == EXEC1) || (r_state == EXEC2));

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            FETCH: w_next = EXEC1;
            EXEC1: begin
                if (w_stp) begin
                    w_next = HALT;
                end else if (w_mlr) begin
                    w_next = MWAIT;
                end else if (extra1) begin
                    w_next = EXEC2;
                end else begin
                    w_next = FETCH;
                end
            end
            MWAIT: if (mul_done || w_wait_max) w_next = EXEC2;
            EXEC2: w_next = FETCH;
            HALT:  if (run) w_next = FETCH;
            default: w_next = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: IR is a single control register, not a memory, so it is reset to a known word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir <= 16'h0000;
        end else if (r_state == EXEC1) begin
            r_ir <= instr_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait <= '0;
        end else if (r_state == MWAIT) begin
            r_wait <= r_wait + WAIT_W'(1);
        end else begin
            r_wait <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mul_err <= 1'b0;
        end else if (w_timeout) begin
            r_mul_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + RETIRE_W'(1);
        end
    end

    assign fe        = (r_state == FETCH);
    assign e1        = (r_state == EXEC1);
    assign e2        = (r_state == EXEC2);
    assign halted    = (r_state == HALT);
    assign mul_start = (r_state == EXEC1) && w_mlr;
    assign mul_err   = r_mul_err;
    assign retired   = r_retired;

endmodule : phase_sequencer

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: phase sequences, instruction hold, multiplier
// handshake and timeout, halt/run and asynchronous reset, against hand-computed values.
module tb_phase_sequencer;

    localparam int MUL_TIMEOUT = 15;
    localparam int RETIRE_W    = 16;

    // Phase vector layout: {fe, e1, e2, halted, mul_start}
    localparam logic [4:0] PH_FE    = 5'b10000;
    localparam logic [4:0] PH_E1    = 5'b01000;
    localparam logic [4:0] PH_E1_MS = 5'b01001;
    localparam logic [4:0] PH_E2    = 5'b00100;
    localparam logic [4:0] PH_WAIT  = 5'b00000;
    localparam logic [4:0] PH_HALT  = 5'b00010;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [15:0]         instr_q;
    logic                extra1;
    logic                mul_done;
    logic                run;
    logic [15:0]         instr;
    logic                fe;
    logic                e1;
    logic                e2;
    logic                mul_start;
    logic                halted;
    logic                mul_err;
    logic [RETIRE_W-1:0] retired;

    logic [4:0]          ph;
    logic [RETIRE_W-1:0] exp_ret;
    int                  total = 0;
    int                  bad   = 0;

    assign ph = {fe, e1, e2, halted, mul_start};

    phase_sequencer #(
        .MUL_TIMEOUT(MUL_TIMEOUT),
        .RETIRE_W   (RETIRE_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .instr_q  (instr_q),
        .extra1   (extra1),
        .mul_done (mul_done),
        .run      (run),
        .instr    (instr),
        .fe       (fe),
        .e1       (e1),
        .e2       (e2),
        .mul_start(mul_start),
        .halted   (halted),
        .mul_err  (mul_err),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n  = 1'b0;
        instr_q  = 16'h0000;
        extra1   = 1'b0;
        mul_done = 1'b0;
        run      = 1'b0;
        #12;
        total++;
        if (ph !== PH_FE) begin
            bad++;
            $display("FAIL reset_phase: got %b want %b", ph, PH_FE);
        end
        total++;
        if (retired !== '0 || mul_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_counters: got retired=%0d mul_err=%b want 0/0", retired, mul_err);
        end
        total++;
        if (instr !== 16'h0000) begin
            bad++;
            $display("FAIL reset_ir: got %h want 0000", instr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        exp_ret = '0;
    endtask

    task automatic test_single_cycle;
        instr_q = 16'h0800;
        extra1  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ph !== PH_FE) begin
                bad++;
                $display("FAIL adr_fe[%0d]: got %b want %b", i, ph, PH_FE);
            end
            step;
            total++;
            if (ph !== PH_E1 || instr !== 16'h0800) begin
                bad++;
                $display("FAIL adr_e1[%0d]: got ph=%b instr=%h want ph=%b instr=0800", i, ph, instr, PH_E1);
            end
            step;
            exp_ret++;
            total++;
            if (retired !== exp_ret) begin
                bad++;
                $display("FAIL adr_retired[%0d]: got %0d want %0d", i, retired, exp_ret);
            end
        end
    endtask

    task automatic test_two_cycle;
        instr_q = 16'hC000;
        extra1  = 1'b1;
        step;
        total++;
        if (ph !== PH_E1 || instr !== 16'hC000) begin
            bad++;
            $display("FAIL lda_e1: got ph=%b instr=%h want ph=%b instr=c000", ph, instr, PH_E1);
        end
        step;
        instr_q = 16'h1234;
        extra1  = 1'b0;
        #1;
        total++;
        if (ph !== PH_E2 || instr !== 16'hC000) begin
            bad++;
            $display("FAIL lda_e2_hold: got ph=%b instr=%h want ph=%b instr=c000", ph, instr, PH_E2);
        end
        total++;
        if (retired !== exp_ret) begin
            bad++;
            $display("FAIL lda_no_early_retire: got %0d want %0d", retired, exp_ret);
        end
        step;
        exp_ret++;
        total++;
        if (ph !== PH_FE || retired !== exp_ret) begin
            bad++;
            $display("FAIL lda_retire: got ph=%b retired=%0d want ph=%b retired=%0d", ph, retired, PH_FE, exp_ret);
        end
    endtask

    task automatic test_mlr_done;
        instr_q = 16'h4800;
        extra1  = 1'b0;
        step;
        total++;
        if (ph !== PH_E1_MS || instr !== 16'h4800) begin
            bad++;
            $display("FAIL mlr_start: got ph=%b instr=%h want ph=%b instr=4800", ph, instr, PH_E1_MS);
        end
        mul_done = 1'b1;
        step;
        mul_done = 1'b0;
        instr_q  = 16'hFFFF;
        #1;
        total++;
        if (ph !== PH_WAIT || instr !== 16'h4800) begin
            bad++;
            $display("FAIL mlr_wait1: got ph=%b instr=%h want ph=%b instr=4800", ph, instr, PH_WAIT);
        end
        step;
        total++;
        if (ph !== PH_WAIT) begin
            bad++;
            $display("FAIL mlr_wait2: got %b want %b", ph, PH_WAIT);
        end
        step;
        mul_done = 1'b1;
        total++;
        if (ph !== PH_WAIT) begin
            bad++;
            $display("FAIL mlr_wait3: got %b want %b", ph, PH_WAIT);
        end
        step;
        mul_done = 1'b0;
        total++;
        if (ph !== PH_E2 || instr !== 16'h4800 || mul_err !== 1'b0) begin
            bad++;
            $display("FAIL mlr_e2: got ph=%b instr=%h err=%b want ph=%b instr=4800 err=0", ph, instr, mul_err, PH_E2);
        end
        step;
        exp_ret++;
        total++;
        if (ph !== PH_FE || retired !== exp_ret) begin
            bad++;
            $display("FAIL mlr_retire: got ph=%b retired=%0d want ph=%b retired=%0d", ph, retired, PH_FE, exp_ret);
        end
    endtask

    task automatic test_mlr_timeout;
        int n;
        n        = 0;
        instr_q  = 16'h4800;
        mul_done = 1'b0;
        step;
        total++;
        if (ph !== PH_E1_MS) begin
            bad++;
            $display("FAIL tmo_start: got %b want %b", ph, PH_E1_MS);
        end
        step;
        while (ph === PH_WAIT && n < 40) begin
            n++;
            total++;
            if (mul_err !== 1'b0) begin
                bad++;
                $display("FAIL tmo_err_early[%0d]: got %b want 0", n, mul_err);
            end
            step;
        end
        total++;
        if (n !== MUL_TIMEOUT + 1) begin
            bad++;
            $display("FAIL tmo_wait_len: got %0d want %0d", n, MUL_TIMEOUT + 1);
        end
        total++;
        if (ph !== PH_E2 || mul_err !== 1'b1) begin
            bad++;
            $display("FAIL tmo_e2: got ph=%b err=%b want ph=%b err=1", ph, mul_err, PH_E2);
        end
        step;
        exp_ret++;
        total++;
        if (ph !== PH_FE || retired !== exp_ret) begin
            bad++;
            $display("FAIL tmo_retire: got ph=%b retired=%0d want ph=%b retired=%0d", ph, retired, PH_FE, exp_ret);
        end
    endtask

    task automatic test_halt;
        instr_q = 16'h0000;
        extra1  = 1'b1;
        step;
        total++;
        if (ph !== PH_E1) begin
            bad++;
            $display("FAIL stp_e1: got %b want %b", ph, PH_E1);
        end
        step;
        instr_q = 16'h0800;
        extra1  = 1'b0;
        total++;
        if (ph !== PH_HALT || retired !== exp_ret) begin
            bad++;
            $display("FAIL stp_halt: got ph=%b retired=%0d want ph=%b retired=%0d", ph, retired, PH_HALT, exp_ret);
        end
        for (int i = 0; i < 10; i++) begin
            step;
            total++;
            if (ph !== PH_HALT) begin
                bad++;
                $display("FAIL stp_hold[%0d]: got %b want %b", i, ph, PH_HALT);
            end
        end
        run = 1'b1;
        step;
        run = 1'b0;
        total++;
        if (ph !== PH_FE || retired !== exp_ret || mul_err !== 1'b1) begin
            bad++;
            $display("FAIL stp_run: got ph=%b retired=%0d err=%b want ph=%b retired=%0d err=1", ph, retired, mul_err, PH_FE, exp_ret);
        end
    endtask

    task automatic test_run_held;
        instr_q = 16'h0000;
        run     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step;
            total++;
            if (ph !== PH_E1) begin
                bad++;
                $display("FAIL runheld_e1[%0d]: got %b want %b", i, ph, PH_E1);
            end
            step;
            total++;
            if (ph !== PH_HALT) begin
                bad++;
                $display("FAIL runheld_halt[%0d]: got %b want %b", i, ph, PH_HALT);
            end
            step;
            total++;
            if (ph !== PH_FE || retired !== exp_ret) begin
                bad++;
                $display("FAIL runheld_fe[%0d]: got ph=%b retired=%0d want ph=%b retired=%0d", i, ph, retired, PH_FE, exp_ret);
            end
        end
        run = 1'b0;
    endtask

    task automatic test_reset_mid;
        instr_q = 16'h4800;
        step;
        step;
        step;
        total++;
        if (ph !== PH_WAIT) begin
            bad++;
            $display("FAIL rstmid_wait: got %b want %b", ph, PH_WAIT);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (ph !== PH_FE || retired !== '0 || mul_err !== 1'b0 || instr !== 16'h0000) begin
            bad++;
            $display("FAIL rstmid_async: got ph=%b retired=%0d err=%b instr=%h want ph=%b retired=0 err=0 instr=0000",
                     ph, retired, mul_err, instr, PH_FE);
        end
        @(negedge clk);
        reset_n = 1'b1;
        exp_ret = '0;
        instr_q = 16'h0800;
        step;
        total++;
        if (ph !== PH_E1) begin
            bad++;
            $display("FAIL rstmid_restart: got %b want %b", ph, PH_E1);
        end
        step;
        exp_ret++;
        total++;
        if (ph !== PH_FE || retired !== exp_ret) begin
            bad++;
            $display("FAIL rstmid_retire: got ph=%b retired=%0d want ph=%b retired=%0d", ph, retired, PH_FE, exp_ret);
        end
    endtask

    initial begin
        test_reset;
        test_single_cycle;
        test_two_cycle;
        test_mlr_done;
        test_mlr_timeout;
        test_halt;
        test_run_held;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got no completion want completion within 20000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_phase_sequencer
